// File: rtl/vending_machine_if.sv
// Signal bundle between the vending controller and its front panel / coin mechanism.
// The master side drives coins, buttons and return requests; the slave is the controller.
interface vending_machine_if;
  logic [2:0] i_input_coin;
  logic [3:0] i_select_item;
  logic       i_trigger_return;
  logic [3:0] o_available_item;
  logic [3:0] o_output_item;
  logic [2:0] o_return_coin;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return,
    input  o_available_item, o_output_item, o_return_coin
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return,
    output o_available_item, o_output_item, o_return_coin
  );
endinterface

// File: rtl/vending_machine.sv
// Coin-operated vending controller: accumulates a balance from 100/500/1000 coins, dispenses
// one item per select edge, and pays the balance back greedily on request or after inactivity.
module vending_machine #(
  parameter int ITEM0_PRICE = 400,
  parameter int ITEM1_PRICE = 500,
  parameter int ITEM2_PRICE = 1000,
  parameter int ITEM3_PRICE = 2000,
  parameter int WAIT_TIME   = 100,
  parameter int BAL_W       = 16
) (
  input logic              clk,
  input logic              reset_n,
  vending_machine_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RETURN} state_t;

  localparam int TMR_W = $clog2(WAIT_TIME + 1);
  localparam logic [BAL_W:0] BAL_MAX = {1'b0, {BAL_W{1'b1}}};
  localparam logic [BAL_W-1:0] PRICE [4] = '{
    BAL_W'(ITEM0_PRICE), BAL_W'(ITEM1_PRICE), BAL_W'(ITEM2_PRICE), BAL_W'(ITEM3_PRICE)
  };

  state_t           state;
  logic [BAL_W-1:0] balance;
  logic [TMR_W-1:0] timer;
  logic [3:0]       sel_q;

  logic [BAL_W:0]   coin_val;
  logic [BAL_W:0]   coin_sum;
  logic             coin_ok;
  logic [3:0]       sel_edge;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             dispense;
  logic [3:0]       dispense_oh;
  logic [BAL_W-1:0] bal_idle;
  logic             activity;
  logic             timeout;
  logic [2:0]       ret_coin;
  logic [BAL_W-1:0] ret_val;
  logic [3:0]       avail;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    coin_val = '0;
    if (bus.i_input_coin[0]) coin_val = coin_val + (BAL_W+1)'(100);
    if (bus.i_input_coin[1]) coin_val = coin_val + (BAL_W+1)'(500);
    if (bus.i_input_coin[2]) coin_val = coin_val + (BAL_W+1)'(1000);
    coin_sum = {1'b0, balance} + coin_val;
    coin_ok  = (coin_sum <= BAL_MAX);

    // Lowest-index rising edge wins; higher simultaneous edges are dropped.
    sel_edge = bus.i_select_item & ~sel_q;
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (sel_edge[k]) begin
        pick     = 2'(k);
        pick_vld = 1'b1;
      end
    end
    dispense    = pick_vld && (balance >= PRICE[pick]);
    dispense_oh = dispense ? (4'b0001 << pick) : 4'b0000;

    bal_idle = balance;
    if (coin_ok)  bal_idle = coin_sum[BAL_W-1:0];
    if (dispense) bal_idle = bal_idle - PRICE[pick];

    activity = (|bus.i_input_coin) || (|sel_edge);
    timeout  = !activity && (balance != '0) && (timer == TMR_W'(WAIT_TIME - 1));

    // Greedy change: largest coin that still fits; nothing when already empty.
    ret_coin = 3'b000;
    ret_val  = '0;
    if (balance >= BAL_W'(1000)) begin
      ret_coin = 3'b100;
      ret_val  = BAL_W'(1000);
    end else if (balance >= BAL_W'(500)) begin
      ret_coin = 3'b010;
      ret_val  = BAL_W'(500);
    end else if (balance != '0) begin
      ret_coin = 3'b001;
      ret_val  = BAL_W'(100);
    end

    for (int k = 0; k < 4; k++) avail[k] = (balance >= PRICE[k]);
  end

  assign bus.o_available_item = avail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      balance           <= '0;
      timer             <= '0;
      sel_q             <= '0;
      bus.o_output_item <= '0;
      bus.o_return_coin <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sel_q             <= bus.i_select_item;
      bus.o_output_item <= '0;
      bus.o_return_coin <= '0;
      case (state)
        ST_IDLE: begin
          balance           <= bal_idle;
          bus.o_output_item <= dispense_oh;
          if (activity || balance == '0) timer <= '0;
          else                           timer <= timer + 1'b1;
          // Only leave for RETURN when there is something left to hand back.
          if (bal_idle != '0 && (bus.i_trigger_return || timeout)) begin
            state <= ST_RETURN;
            timer <= '0;
          end
        end
        ST_RETURN: begin
          balance           <= balance - ret_val;
          bus.o_return_coin <= ret_coin;
          if (balance == ret_val) begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed-vector bench for vending_machine: stimulus pushes expected dispense/return pulses
// into a scoreboard queue, and a negedge monitor pops and compares whenever a pulse appears.
module tb_vending_machine;

  localparam int WAIT = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_pulse_cyc = -10;

  typedef struct {
    string      name;
    logic [6:0] pulse;  // {item[3:0], coin[2:0]}
    int         at;     // absolute cycle, -1 = not checked
    bit         chain;  // must follow the previous pulse by exactly one cycle
  } exp_t;

  exp_t exp_q[$];

  vending_machine_if bus ();

  vending_machine #(
    .ITEM0_PRICE(400), .ITEM1_PRICE(500), .ITEM2_PRICE(1000), .ITEM3_PRICE(2000),
    .WAIT_TIME(WAIT), .BAL_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [6:0] item(input int k);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    return {oh, 3'b000};
  endfunction

  function automatic logic [6:0] coin(input logic [2:0] c);
    return {4'b0000, c};
  endfunction

  task automatic push(input string name, input logic [6:0] pulse, input int at, input bit chain);
    exp_t e;
    e.name = name; e.pulse = pulse; e.at = at; e.chain = chain;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_output_item != 4'b0 || bus.o_return_coin != 3'b0) begin
      check("item_coin_exclusive", 32'(|bus.o_output_item && |bus.o_return_coin), 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'({bus.o_output_item, bus.o_return_coin}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, 32'({bus.o_output_item, bus.o_return_coin}), 32'(e.pulse));
        if (e.chain)        check({e.name, "_cycle"}, 32'(cyc), 32'(last_pulse_cyc + 1));
        else if (e.at >= 0) check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
      end
      last_pulse_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [2:0] c, input int n);
    repeat (n) begin
      bus.i_input_coin = c;
      step();
    end
    bus.i_input_coin = 3'b000;
  endtask

  task automatic press(input logic [3:0] sel, input int hold, input string nm,
                       input logic [6:0] pulse, input bit expect_it);
    bus.i_select_item = sel;
    if (expect_it) push(nm, pulse, cyc + 1, 1'b0);
    repeat (hold) step();
    bus.i_select_item = 4'b0000;
    step();
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.i_input_coin     = 3'b000;
    bus.i_select_item    = 4'b0000;
    bus.i_trigger_return = 1'b0;
    repeat (2) step();
    check("reset_avail", 32'(bus.o_available_item), 32'h0);
    check("reset_item",  32'(bus.o_output_item),    32'h0);
    check("reset_coin",  32'(bus.o_return_coin),    32'h0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_avail", 32'(bus.o_available_item), 32'h0);

    // Coin accumulation and affordability thresholds.
    insert(3'b001, 5);
    check("avail_500",  32'(bus.o_available_item), 32'b0011);
    insert(3'b010, 2);
    check("avail_1500", 32'(bus.o_available_item), 32'b0111);
    insert(3'b100, 4);
    check("avail_5500", 32'(bus.o_available_item), 32'b1111);

    // Purchases: 5500 -> 2700 -> 700.
    press(4'b0001, 1, "buy_item0_a", item(0), 1'b1);
    press(4'b0001, 1, "buy_item0_b", item(0), 1'b1);
    press(4'b0010, 1, "buy_item1_a", item(1), 1'b1);
    press(4'b0010, 1, "buy_item1_b", item(1), 1'b1);
    press(4'b0100, 1, "buy_item2",   item(2), 1'b1);
    check("avail_2700", 32'(bus.o_available_item), 32'b1111);
    press(4'b1000, 1, "buy_item3",   item(3), 1'b1);
    check("avail_700",  32'(bus.o_available_item), 32'b0011);

    // Inactivity timeout: 700 + 1600 = 2300 returned as 1000,1000,100,100,100.
    insert(3'b001, 1);
    insert(3'b010, 1);
    insert(3'b100, 1);
    n0 = cyc;
    push("timeout_1000_a", coin(3'b100), n0 + WAIT + 1, 1'b0);
    push("timeout_1000_b", coin(3'b100), -1, 1'b1);
    push("timeout_100_a",  coin(3'b001), -1, 1'b1);
    push("timeout_100_b",  coin(3'b001), -1, 1'b1);
    push("timeout_100_c",  coin(3'b001), -1, 1'b1);
    drain("timeout", WAIT + 20);
    step();
    check("avail_after_timeout", 32'(bus.o_available_item), 32'h0);

    // Requested return of 4800, trigger held afterwards.
    insert(3'b001, 3);
    insert(3'b010, 3);
    insert(3'b100, 3);
    check("avail_4800", 32'(bus.o_available_item), 32'b1111);
    bus.i_trigger_return = 1'b1;
    step();
    n0 = cyc;
    push("ret_1000_a", coin(3'b100), n0 + 1, 1'b0);
    push("ret_1000_b", coin(3'b100), -1, 1'b1);
    push("ret_1000_c", coin(3'b100), -1, 1'b1);
    push("ret_1000_d", coin(3'b100), -1, 1'b1);
    push("ret_500",    coin(3'b010), -1, 1'b1);
    push("ret_100_a",  coin(3'b001), -1, 1'b1);
    push("ret_100_b",  coin(3'b001), -1, 1'b1);
    push("ret_100_c",  coin(3'b001), -1, 1'b1);
    drain("trigger", 20);
    repeat (10) step();
    check("avail_after_return", 32'(bus.o_available_item), 32'h0);
    bus.i_trigger_return = 1'b0;

    // Held button dispenses once; exact-price purchase empties the balance.
    insert(3'b010, 1);
    press(4'b0010, 3, "held_item1", item(1), 1'b1);
    check("avail_after_held", 32'(bus.o_available_item), 32'h0);

    // Insufficient funds, then simultaneous edges with lowest index winning.
    insert(3'b100, 1);
    insert(3'b010, 1);
    check("avail_1500_b", 32'(bus.o_available_item), 32'b0111);
    press(4'b1000, 1, "poor_item3", item(3), 1'b0);
    check("avail_no_deduct", 32'(bus.o_available_item), 32'b0111);
    press(4'b1010, 1, "multi_1_3", item(1), 1'b1);
    check("avail_1000", 32'(bus.o_available_item), 32'b0111);
    press(4'b1100, 1, "multi_2_3", item(2), 1'b1);
    check("avail_zero", 32'(bus.o_available_item), 32'h0);

    // Coin and dispense in the same cycle: 500 + 100 - 500 = 100, then +300 = 400.
    insert(3'b010, 1);
    bus.i_input_coin  = 3'b001;
    bus.i_select_item = 4'b0010;
    push("coin_and_buy", item(1), cyc + 1, 1'b0);
    step();
    bus.i_input_coin  = 3'b000;
    bus.i_select_item = 4'b0000;
    step();
    check("avail_100", 32'(bus.o_available_item), 32'h0);
    insert(3'b001, 3);
    check("avail_400", 32'(bus.o_available_item), 32'b0001);

    // Reset in the middle of RETURN (balance 3400).
    insert(3'b100, 3);
    bus.i_trigger_return = 1'b1;
    step();
    n0 = cyc;
    bus.i_trigger_return = 1'b0;
    push("pre_reset_1000_a", coin(3'b100), n0 + 1, 1'b0);
    push("pre_reset_1000_b", coin(3'b100), n0 + 2, 1'b0);
    step();
    step();
    @(negedge clk);
    #2;
    check("coin_before_reset", 32'(bus.o_return_coin), 32'(3'b100));
    reset_n = 1'b0;
    #1;
    check("reset_mid_coin",  32'(bus.o_return_coin),    32'h0);
    check("reset_mid_item",  32'(bus.o_output_item),    32'h0);
    check("reset_mid_avail", 32'(bus.o_available_item), 32'h0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("post_reset_avail", 32'(bus.o_available_item), 32'h0);
    check("post_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
